// File: rtl/rng_arbiter_if.sv
// Request/delivery bus between the requesters, the shared randomGenerator and rng_arbiter.
// The arbiter connects through the slave modport; the requester/generator side uses master.
interface rng_arbiter_if #(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_4bit;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rnd_valid;
  logic [15:0]     rnd_data;
  logic            rng_err;
  logic            en_rng;
  logic [15:0]     rng_out;
  logic [15:0]     rng_out_4bit;
  logic            rng_done;

  modport slave (
    input  req,
    input  req_4bit,
    input  rng_out,
    input  rng_out_4bit,
    input  rng_done,
    output gnt,
    output rnd_valid,
    output rnd_data,
    output rng_err,
    output en_rng
  );

  modport master (
    output req,
    output req_4bit,
    output rng_out,
    output rng_out_4bit,
    output rng_done,
    input  gnt,
    input  rnd_valid,
    input  rnd_data,
    input  rng_err,
    input  en_rng
  );

endinterface

// File: rtl/rng_arbiter.sv
// Round-robin sharing of one randomGenerator LFSR among NREQ requesters.
// Sequences en_rng/done, returns the 16-bit or 4-bit value to the winner, and flags a stuck generator.
module rng_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic           clock,
  input logic           nrst,
  rng_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   win_q, win_d;
  logic            sel_q, sel_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_rng_q, en_rng_d;
  logic [NREQ-1:0] rnd_valid_q, rnd_valid_d;
  logic [DW-1:0]   rnd_data_q, rnd_data_d;
  logic            rng_err_q, rng_err_d;

  logic            found;
  logic [PW-1:0]   pick;
  int unsigned     scan;
  logic            finish;

  // First pending request at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan = 32'(ptr_q) + i;
      if (scan >= NREQ) begin
        scan = scan - NREQ;
      end
      if (!found && bus.req[PW'(scan)]) begin
        found = 1'b1;
        pick  = PW'(scan);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      win_q       <= '0;
      sel_q       <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      en_rng_q    <= 1'b0;
      rnd_valid_q <= '0;
      rnd_data_q  <= '0;
      rng_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      win_q       <= win_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      en_rng_q    <= en_rng_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      rng_err_q   <= rng_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    win_d       = win_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    en_rng_d    = 1'b0;
    rnd_valid_d = '0;
    rnd_data_d  = rnd_data_q;
    rng_err_d   = rng_err_q;
    finish      = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d    = NREQ'(1) << pick;
          win_d    = pick;
          sel_d    = bus.req_4bit[pick];
          en_rng_d = 1'b1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.rng_done) begin
          rnd_data_d = sel_q ? bus.rng_out_4bit : bus.rng_out;
          finish     = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Generator never answered: hand back zero and latch the error.
          rnd_data_d = '0;
          rng_err_d  = 1'b1;
          finish     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      rnd_valid_d = gnt_q;
      gnt_d       = '0;
      ptr_d       = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      state_d     = IDLE;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.en_rng    = en_rng_q;
  assign bus.rnd_valid = rnd_valid_q;
  assign bus.rnd_data  = rnd_data_q;
  assign bus.rng_err   = rng_err_q;

endmodule
